axis_ctrlsrc_select_n: RTL and testbench
========================================

Name: axis_ctrlsrc_select_n

Overview:
Parametrised N-channel successor to the single-source control-source selector. Picks one of N_CH signed AXIS control sources by `selection` and sign-extends it to MAXIS_DATA_WIDTH on a registered M_AXIS output. Channel changes pass through a programmable settle window, so downstream controllers (Z servo, PAC/PLL feedback) never see a mixed or transient sample. Optional IEEE-754 float output path.

Parameters:
N_CH, 4, number of source channels (2..16)
SAXIS_DATA_WIDTH, 32, input sample width per channel (signed, 2..32)
MAXIS_DATA_WIDTH, 32, output width; must be >= SAXIS_DATA_WIDTH
SEL_WIDTH, 4, width of selection port; must be >= clog2(N_CH)
SETTLE_WIDTH, 8, width of settle_cycles port

Ports:
a_clk  input  1  system clock, all logic rising-edge
a_rst  input  1  asynchronous, active-high reset
S_AXIS_tdata  input  N_CH*SAXIS_DATA_WIDTH  packed lanes; channel k at bits [k*SAXIS_DATA_WIDTH +: SAXIS_DATA_WIDTH]
S_AXIS_tvalid  input  N_CH  per-lane valid
selection  input  SEL_WIDTH  requested channel index
settle_cycles  input  SETTLE_WIDTH  blanking length after a channel switch
M_AXIS_tdata  output  MAXIS_DATA_WIDTH  sign-extended selected sample
M_AXIS_tvalid  output  1  output valid
M_AXIS_FLOAT_tdata  output  32  IEEE-754 single of selected sample
M_AXIS_FLOAT_tvalid  output  1  float valid
active_sel  output  SEL_WIDTH  channel currently routed
switch_busy  output  1  high while in SETTLE
sel_error  output  1  high while selection >= N_CH

Behaviour:
- No tready anywhere. Sources are free-running; the sink must always accept.
- Reset (async assert, sync release):
  - M_AXIS_tdata=0, M_AXIS_tvalid=0.
  - Float outputs: 0.
  - active_sel=0, switch_busy=0, sel_error=0.
  - State RUN, settle counter=0.
- sel_error: registered copy of (selection >= N_CH). An out-of-range selection is ignored and active_sel is unchanged.
- State RUN:
  - Each cycle, if S_AXIS_tvalid[active_sel]=1: M_AXIS_tdata <= sign-extended lane, M_AXIS_tvalid <= 1.
  - Otherwise M_AXIS_tvalid <= 0 and tdata holds its last value.
  - Latency: input to output is exactly 1 cycle.
- Switch trigger (in RUN): selection differs from active_sel and is in range.
  - active_sel <= selection on that edge.
  - If settle_cycles=0: stay in RUN. The next cycle outputs the new lane (no gap beyond normal 1-cycle latency). The output on the trigger edge is still from the old lane.
  - If settle_cycles=S>0: go to SETTLE with counter=S, and M_AXIS_tvalid <= 0 on that edge.
- State SETTLE:
  - switch_busy=1, M_AXIS_tvalid=0, tdata holds the last pre-switch value.
  - Counter decrements each cycle; the exit edge goes to RUN.
  - Exactly S cycles have tvalid=0, then the first new-lane sample appears.
- Selection change during SETTLE to a different valid index: active_sel relatches and the counter reloads from settle_cycles (restart).
- Changing settle_cycles mid-SETTLE has no effect until the next switch.
- Sign extension: upper MAXIS-SAXIS bits replicate bit SAXIS_DATA_WIDTH-1. If the widths are equal, the lane passes through unchanged.
- Reset asserted mid-SETTLE: immediate return to reset values; channel 0 is active after release.

Optional Feature:
CTRLSRC_FLOAT_EN
- Defined:
  - 3-stage pipelined signed-integer to float32 converter fed from the registered selected sample (pre-extension, SAXIS_DATA_WIDTH bits).
  - Stages: abs/sign, leading-one detect, normalise and round-to-nearest-even.
  - 0 maps to +0.0. -2^(SAXIS_DATA_WIDTH-1) is exact.
  - M_AXIS_FLOAT_tvalid equals M_AXIS_tvalid delayed 3 cycles, so float lags integer by 3 cycles.
  - Converter pipeline resets to 0.
- Undefined: M_AXIS_FLOAT_tdata and M_AXIS_FLOAT_tvalid are tied to 0, and no converter logic is generated.

Test Plan:
- Reset/idle: assert a_rst for 5 cycles with all lanes valid -> all outputs 0; after release, channel 0 data 0x00001234 appears on M_AXIS_tdata one cycle later with tvalid=1.
- Sign extension (SAXIS=24, MAXIS=32): lane 0 = 0x800001 -> 0xFF800001; lane 0 = 0x7FFFFF -> 0x007FFFFF.
- Settled switch:
  - Setup: settle_cycles=3, lanes k carry constant k+1, switch selection 0->2.
  - Expected: switch_busy high for exactly 3 cycles, tvalid=0 in those 3 cycles, tdata holds 1, then 3 appears with tvalid=1 and active_sel=2.
- Zero-settle and restart:
  - settle_cycles=0, switch 1->3: value 4 appears on the cycle after the old value, with no tvalid gap.
  - settle_cycles=5, switch 0->1, then 1->2 two cycles later: 5 more blank cycles from the second change, then value 3.
- Invalid select / gated valid:
  - selection=N_CH (4): sel_error=1, active_sel unchanged, data continues.
  - Drop S_AXIS_tvalid of the active lane for 2 cycles: M_AXIS_tvalid low for those 2 cycles (1-cycle delayed), tdata held.
- Float (CTRLSRC_FLOAT_EN defined):
  - 1 -> 0x3F800000
  - -2 -> 0xC0000000
  - 0 -> 0x00000000
  - 0x7FFFFFFF -> 0x4F000000 (round to even)
  - Each result 3 cycles after its integer output.

Source files
------------

// File: rtl/axis_ctrlsrc_select_n.sv
// N-channel signed AXIS control-source selector with settle blanking.
// Optional float32 output path enabled by defining CTRLSRC_FLOAT_EN.
module axis_ctrlsrc_select_n #(
  parameter int N_CH             = 4,
  parameter int SAXIS_DATA_WIDTH = 32,
  parameter int MAXIS_DATA_WIDTH = 32,
  parameter int SEL_WIDTH        = 4,
  parameter int SETTLE_WIDTH     = 8
) (
  input  logic                               a_clk,
  input  logic                               a_rst,
  input  logic [N_CH*SAXIS_DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic [N_CH-1:0]                    S_AXIS_tvalid,
  input  logic [SEL_WIDTH-1:0]               selection,
  input  logic [SETTLE_WIDTH-1:0]            settle_cycles,
  output logic [MAXIS_DATA_WIDTH-1:0]        M_AXIS_tdata,
  output logic                               M_AXIS_tvalid,
  output logic [31:0]                        M_AXIS_FLOAT_tdata,
  output logic                               M_AXIS_FLOAT_tvalid,
  output logic [SEL_WIDTH-1:0]               active_sel,
  output logic                               switch_busy,
  output logic                               sel_error
);

  localparam int SW = SAXIS_DATA_WIDTH;
  localparam int MW = MAXIS_DATA_WIDTH;
  localparam logic [SEL_WIDTH:0] NCH_L = (SEL_WIDTH+1)'(N_CH);

  typedef enum logic {RUN, SETTLE} state_t;

  state_t                  state;
  logic [SETTLE_WIDTH-1:0] cnt;
  logic signed [SW-1:0]    sample_q;
  logic [SW-1:0]           lane_data;
  logic                    lane_valid;
  logic                    sel_ok;
  logic                    sel_new;

  always_comb begin
    lane_data  = '0;
    lane_valid = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (active_sel == SEL_WIDTH'(k)) begin
        lane_data  = S_AXIS_tdata[k*SW +: SW];
        lane_valid = S_AXIS_tvalid[k];
      end
    end
  end

  assign sel_ok  = {1'b0, selection} < NCH_L;
  assign sel_new = sel_ok && (selection != active_sel);

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state         <= RUN;
      cnt           <= '0;
      sample_q      <= '0;
      M_AXIS_tvalid <= 1'b0;
      active_sel    <= '0;
      switch_busy   <= 1'b0;
      sel_error     <= 1'b0;
    end else begin
      sel_error <= !sel_ok;
      unique case (state)
        RUN: begin
          if (sel_new && settle_cycles != '0) begin
            active_sel    <= selection;
            cnt           <= settle_cycles;
            state         <= SETTLE;
            switch_busy   <= 1'b1;
            M_AXIS_tvalid <= 1'b0;
          end else begin
            if (sel_new) active_sel <= selection;
            M_AXIS_tvalid <= lane_valid;
            if (lane_valid) sample_q <= lane_data;
          end
        end
        SETTLE: begin
          M_AXIS_tvalid <= 1'b0;
          if (sel_new) begin
            // restart the window on a fresh channel request
            active_sel <= selection;
            cnt        <= settle_cycles;
            if (settle_cycles == '0) begin
              state       <= RUN;
              switch_busy <= 1'b0;
            end
          end else if (cnt == SETTLE_WIDTH'(1)) begin
            state         <= RUN;
            switch_busy   <= 1'b0;
            M_AXIS_tvalid <= lane_valid;
            if (lane_valid) sample_q <= lane_data;
          end else begin
            cnt <= cnt - SETTLE_WIDTH'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign M_AXIS_tdata = MW'(sample_q);

`ifdef CTRLSRC_FLOAT_EN
  logic [SW-1:0] mag;
  logic          s1_sign, s1_v;
  logic [31:0]   s1_abs;
  logic          s2_sign, s2_v, s2_zero;
  logic [31:0]   s2_abs;
  logic [4:0]    s2_pos;
  logic [4:0]    pos;
  logic [31:0]   norm;
  logic          rnd;
  logic [24:0]   mant;
  logic [7:0]    expo;
  logic [22:0]   frac;

  assign mag = sample_q[SW-1] ? (~sample_q) + SW'(1) : sample_q;

  always_comb begin
    pos = '0;
    for (int i = 0; i < 32; i++) begin
      if (s1_abs[i]) pos = 5'(i);
    end
  end

  // round-to-nearest-even on the bits below the 24-bit significand
  always_comb begin
    norm = s2_abs << (5'd31 - s2_pos);
    rnd  = norm[7] & ((|norm[6:0]) | norm[8]);
    mant = {1'b0, norm[31:8]} + 25'(rnd);
    expo = 8'd127 + {3'b0, s2_pos} + {7'b0, mant[24]};
    frac = mant[24] ? 23'd0 : mant[22:0];
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      s1_sign             <= 1'b0;
      s1_v                <= 1'b0;
      s1_abs              <= '0;
      s2_sign             <= 1'b0;
      s2_v                <= 1'b0;
      s2_zero             <= 1'b0;
      s2_abs              <= '0;
      s2_pos              <= '0;
      M_AXIS_FLOAT_tdata  <= '0;
      M_AXIS_FLOAT_tvalid <= 1'b0;
    end else begin
      s1_sign             <= sample_q[SW-1];
      s1_abs              <= 32'(mag);
      s1_v                <= M_AXIS_tvalid;
      s2_sign             <= s1_sign;
      s2_abs              <= s1_abs;
      s2_pos              <= pos;
      s2_zero             <= (s1_abs == '0);
      s2_v                <= s1_v;
      M_AXIS_FLOAT_tdata  <= s2_zero ? 32'd0 : {s2_sign, expo, frac};
      M_AXIS_FLOAT_tvalid <= s2_v;
    end
  end
`else
  assign M_AXIS_FLOAT_tdata  = '0;
  assign M_AXIS_FLOAT_tvalid = 1'b0;
`endif

endmodule

// File: tb/tb_axis_ctrlsrc_select_n.sv
// Directed scoreboard bench for axis_ctrlsrc_select_n.
// Float checks follow CTRLSRC_FLOAT_EN.
module tb_axis_ctrlsrc_select_n;

  logic         a_clk = 1'b0;
  logic         a_rst = 1'b1;
  logic [127:0] s_tdata = '0;
  logic [3:0]   s_tvalid = 4'hF;
  logic [3:0]   sel = '0;
  logic [7:0]   settle = '0;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic [31:0]  f_tdata;
  logic         f_tvalid;
  logic [3:0]   act;
  logic         busy;
  logic         err;

  logic [47:0]  s24_tdata = '0;
  logic [1:0]   s24_tvalid = 2'b11;
  logic [1:0]   sel24 = '0;
  logic [7:0]   settle24 = '0;
  logic [31:0]  m24_tdata;
  logic         m24_tvalid;
  logic [31:0]  f24_tdata;
  logic         f24_tvalid;
  logic [1:0]   act24;
  logic         busy24;
  logic         err24;

  always #5 a_clk = ~a_clk;

  axis_ctrlsrc_select_n dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid),
    .selection(sel), .settle_cycles(settle),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid),
    .M_AXIS_FLOAT_tdata(f_tdata), .M_AXIS_FLOAT_tvalid(f_tvalid),
    .active_sel(act), .switch_busy(busy), .sel_error(err)
  );

  axis_ctrlsrc_select_n #(
    .N_CH(2), .SAXIS_DATA_WIDTH(24), .MAXIS_DATA_WIDTH(32),
    .SEL_WIDTH(2), .SETTLE_WIDTH(8)
  ) dut24 (
    .a_clk(a_clk), .a_rst(a_rst),
    .S_AXIS_tdata(s24_tdata), .S_AXIS_tvalid(s24_tvalid),
    .selection(sel24), .settle_cycles(settle24),
    .M_AXIS_tdata(m24_tdata), .M_AXIS_tvalid(m24_tvalid),
    .M_AXIS_FLOAT_tdata(f24_tdata), .M_AXIS_FLOAT_tvalid(f24_tvalid),
    .active_sel(act24), .switch_busy(busy24), .sel_error(err24)
  );

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] d;
    logic        busy;
    logic [3:0]  act;
    logic        err;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } fexp_t;

  exp_t  q[$];
  fexp_t fq[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t  e;
    fexp_t f;
    @(posedge a_clk);
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".tvalid"}, 32'(m_tvalid), 32'(e.v));
      chk({e.tag, ".tdata"}, m_tdata, e.d);
      chk({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
      chk({e.tag, ".active"}, 32'(act), 32'(e.act));
      chk({e.tag, ".selerr"}, 32'(err), 32'(e.err));
    end
    while (fq.size() > 0 && fq[0].due == cyc) begin
      f = fq.pop_front();
      chk("float.tdata", f_tdata, f.d);
      chk("float.tvalid", 32'(f_tvalid), 32'd1);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] d,
                      input logic b, input logic [3:0] a, input logic e);
    q.push_back('{tag, v, d, b, a, e});
    tick();
  endtask

  task automatic set_lane(input int k, input logic [31:0] v);
    s_tdata[k*32 +: 32] = v;
  endtask

  task automatic fstep(input logic [31:0] v, input logic [31:0] fv);
    set_lane(0, v);
    q.push_back('{"flt_int", 1'b1, v, 1'b0, 4'd0, 1'b0});
    fq.push_back('{cyc + 4, fv});
    tick();
  endtask

  initial begin
    set_lane(0, 32'h0000_1234);
    repeat (5) tick();
    chk("rst.tdata", m_tdata, 32'd0);
    chk("rst.tvalid", 32'(m_tvalid), 32'd0);
    chk("rst.active", 32'(act), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.selerr", 32'(err), 32'd0);
    chk("rst.ftdata", f_tdata, 32'd0);
    chk("rst.ftvalid", 32'(f_tvalid), 32'd0);
    a_rst = 1'b0;
    step("rel", 1, 32'h1234, 0, 0, 0);

    s24_tdata[23:0] = 24'h800001;
    tick();
    chk("sx.neg", m24_tdata, 32'hFF80_0001);
    s24_tdata[23:0] = 24'h7FFFFF;
    tick();
    chk("sx.pos", m24_tdata, 32'h007F_FFFF);
    chk("sx.valid", 32'(m24_tvalid), 32'd1);

    for (int k = 0; k < 4; k++) set_lane(k, 32'(k + 1));
    settle = 8'd3;
    step("pre", 1, 1, 0, 0, 0);
    sel = 4'd2;
    step("st0", 0, 1, 1, 2, 0);
    step("st1", 0, 1, 1, 2, 0);
    step("st2", 0, 1, 1, 2, 0);
    step("st_out", 1, 3, 0, 2, 0);

    settle = 8'd0;
    sel = 4'd1;
    step("z_a", 1, 3, 0, 1, 0);
    step("z_b", 1, 2, 0, 1, 0);
    sel = 4'd3;
    step("z_old", 1, 2, 0, 3, 0);
    step("z_new", 1, 4, 0, 3, 0);

    sel = 4'd0;
    step("r_a", 1, 4, 0, 0, 0);
    step("r_b", 1, 1, 0, 0, 0);
    settle = 8'd5;
    sel = 4'd1;
    step("r_t1", 0, 1, 1, 1, 0);
    step("r_t2", 0, 1, 1, 1, 0);
    sel = 4'd2;
    step("r_rs", 0, 1, 1, 2, 0);
    settle = 8'd1;
    for (int i = 0; i < 4; i++) step("r_bl", 0, 1, 1, 2, 0);
    step("r_out", 1, 3, 0, 2, 0);

    settle = 8'd0;
    sel = 4'd4;
    set_lane(2, 32'h55);
    step("inv_a", 1, 32'h55, 0, 2, 1);
    step("inv_b", 1, 32'h55, 0, 2, 1);
    sel = 4'd2;
    step("inv_c", 1, 32'h55, 0, 2, 0);

    s_tvalid[2] = 1'b0;
    set_lane(2, 32'h66);
    step("gv_a", 0, 32'h55, 0, 2, 0);
    step("gv_b", 0, 32'h55, 0, 2, 0);
    s_tvalid[2] = 1'b1;
    step("gv_c", 1, 32'h66, 0, 2, 0);

    settle = 8'd5;
    sel = 4'd0;
    step("ms", 0, 32'h66, 1, 0, 0);
    a_rst = 1'b1;
    #1;
    chk("mrst.tdata", m_tdata, 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.tvalid", 32'(m_tvalid), 32'd0);
    tick();
    a_rst = 1'b0;
    settle = 8'd0;
    step("mrst_rel", 1, 1, 0, 0, 0);

`ifdef CTRLSRC_FLOAT_EN
    fstep(32'd1, 32'h3F80_0000);
    fstep(32'hFFFF_FFFE, 32'hC000_0000);
    fstep(32'd0, 32'h0000_0000);
    fstep(32'h7FFF_FFFF, 32'h4F00_0000);
    repeat (4) tick();
`else
    tick();
    chk("nofloat.tdata", f_tdata, 32'd0);
    chk("nofloat.tvalid", 32'(f_tvalid), 32'd0);
`endif

    if (q.size() != 0 || fq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: pending %0d expected 0", q.size() + fq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
